// File: rtl/timer_pkg.sv
// Shared defaults and sizing helper for the timer bank and its channels.
package timer_pkg;

   localparam int unsigned DEF_CHANNELS = 4;
   localparam int unsigned DEF_WIDTH    = 11;
   localparam int unsigned DEF_PRESCALE = 4;

   // Index width for a range of n values, never narrower than one bit.
   function automatic int unsigned bits_for(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: loadable down-counter with periodic or one-shot expiry.
module timer_channel
   import timer_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             strobe,
   input  logic             load,
   input  logic             halt,
   input  logic [WIDTH-1:0] period,
   input  logic             one_shot,
   output logic             tick,
   output logic             running
);

   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] reload;
   logic             mode_os;

   // Priority: reset, then load (beats halt and expiry), then halt, then counting.
   // Period 0 wraps to all-ones, giving a full 2^WIDTH strobe period.
   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         reload  <= '0;
         mode_os <= 1'b0;
         running <= 1'b0;
         tick    <= 1'b0;
      end else if (load) begin
         count   <= period - WIDTH'(1);
         reload  <= period - WIDTH'(1);
         mode_os <= one_shot;
         running <= 1'b1;
         tick    <= 1'b0;
      end else if (halt) begin
         running <= 1'b0;
         tick    <= 1'b0;
      end else if (running && strobe) begin
         if (count != '0) begin
            count <= count - WIDTH'(1);
            tick  <= 1'b0;
         end else begin
            tick <= 1'b1;
            if (mode_os)
               running <= 1'b0;
            else
               count <= reload;
         end
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/timer_bank.sv
// Bank of independent timer channels sharing one free-running prescaler.
module timer_bank
   import timer_pkg::*;
#(
   parameter int unsigned CHANNELS = DEF_CHANNELS,
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned PRESCALE = DEF_PRESCALE
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [bits_for(CHANNELS)-1:0] startChan,
   input  logic [WIDTH-1:0]              startPeriod,
   input  logic                          startOneShot,
   input  logic [CHANNELS-1:0]           stop,
   output logic [CHANNELS-1:0]           tick,
   output logic [CHANNELS-1:0]           running
);

   localparam int unsigned CW = bits_for(CHANNELS);
   localparam int unsigned PW = bits_for(PRESCALE);

   logic [PW-1:0] presc;
   logic          strobe;

   always_ff @(posedge clk) begin
      if (reset)
         presc <= '0;
      else if (presc == PW'(PRESCALE - 1))
         presc <= '0;
      else
         presc <= presc + PW'(1);
   end

   always_comb begin
      strobe = (presc == '0);
   end

   // An out-of-range startChan matches no channel index, so it is dropped.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic load;

      always_comb begin
         load = start && (startChan == CW'(i));
      end

      timer_channel #(
         .WIDTH(WIDTH)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .strobe   (strobe),
         .load     (load),
         .halt     (stop[i]),
         .period   (startPeriod),
         .one_shot (startOneShot),
         .tick     (tick[i]),
         .running  (running[i])
      );
   end

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: two instances (fast narrow, prescaled default width).
module tb_timer_bank;

   typedef struct {
      int    cyc;
      bit    b;
      int    ch;
      logic  t;
      logic  r;
      string tag;
   } exp_t;

   logic        clk = 1'b0;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   exp_t        sb[$];
   logic [1:0]  mon_obs;

   // Instance A: CHANNELS=4, WIDTH=4, PRESCALE=1
   logic        reset_a, start_a, os_a;
   logic [1:0]  chan_a;
   logic [3:0]  per_a, stop_a, tick_a, run_a;
   // Instance B: CHANNELS=4, WIDTH=11, PRESCALE=4
   logic        reset_b, start_b, os_b;
   logic [1:0]  chan_b;
   logic [10:0] per_b;
   logic [3:0]  stop_b, tick_b, run_b;

   timer_bank #(.CHANNELS(4), .WIDTH(4), .PRESCALE(1)) u_dut_a (
      .clk(clk), .reset(reset_a), .start(start_a), .startChan(chan_a),
      .startPeriod(per_a), .startOneShot(os_a), .stop(stop_a),
      .tick(tick_a), .running(run_a)
   );

   timer_bank #(.CHANNELS(4), .WIDTH(11), .PRESCALE(4)) u_dut_b (
      .clk(clk), .reset(reset_b), .start(start_b), .startChan(chan_b),
      .startPeriod(per_b), .startOneShot(os_b), .stop(stop_b),
      .tick(tick_b), .running(run_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic push(input bit b, input int ch, input int c, input logic t,
                       input logic r, input string tag);
      exp_t e;
      e.cyc = c; e.b = b; e.ch = ch; e.t = t; e.r = r;
      e.tag = $sformatf("%s_%s_ch%0d@%0d", tag, b ? "B" : "A", ch, c);
      sb.push_back(e);
   endtask

   // Expected behaviour k edges after a start edge n0, straight from the period definition.
   task automatic push_win(input bit b, input int ch, input int n0, input int k_from,
                           input int k_to, input int p, input bit os, input string tag);
      for (int k = k_from; k <= k_to; k++) begin
         if (os) push(b, ch, n0 + k, k == p, k < p, tag);
         else    push(b, ch, n0 + k, (k > 0) && (k % p == 0), 1'b1, tag);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_a_t(input int ch, input int p, input bit os, input logic [3:0] stp);
      start_a = 1'b1; chan_a = 2'(ch); per_a = 4'(p); os_a = os; stop_a = stp;
      @(negedge clk);
      start_a = 1'b0; stop_a = '0;
   endtask

   task automatic stop_a_t(input logic [3:0] m);
      stop_a = m;
      @(negedge clk);
      stop_a = '0;
   endtask

   task automatic start_b_t(input int ch, input int p, input bit os);
      start_b = 1'b1; chan_b = 2'(ch); per_b = 11'(p); os_b = os;
      @(negedge clk);
      start_b = 1'b0;
   endtask

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            if (sb[i].b) mon_obs = {tick_b[sb[i].ch], run_b[sb[i].ch]};
            else         mon_obs = {tick_a[sb[i].ch], run_a[sb[i].ch]};
            check_eq(sb[i].tag, {30'b0, mon_obs}, {30'b0, sb[i].t, sb[i].r});
            sb.delete(i);
         end
      end
   end

   initial begin
      int n0, n1, n2, r_b, s1, t1, m;
      reset_a = 1'b1; start_a = 1'b0; os_a = 1'b0; chan_a = '0; per_a = '0; stop_a = '0;
      reset_b = 1'b1; start_b = 1'b0; os_b = 1'b0; chan_b = '0; per_b = '0; stop_b = '0;
      for (int c = 0; c < 4; c++) begin
         push(1'b0, c, 2, 1'b0, 1'b0, "reset");
         push(1'b1, c, 2, 1'b0, 1'b0, "reset");
      end
      idle(2);
      r_b = 2;
      reset_a = 1'b0; reset_b = 1'b0;

      // P=3 periodic on ch0
      n0 = cyc + 1;
      push_win(1'b0, 0, n0, 0, 12, 3, 1'b0, "p3");
      start_a_t(0, 3, 1'b0, 4'b0000);
      idle(12);
      push(1'b0, 0, cyc + 1, 1'b0, 1'b0, "p3_stop");
      stop_a_t(4'b0001);

      // P=5 one-shot on ch2
      n0 = cyc + 1;
      push_win(1'b0, 2, n0, 0, 55, 5, 1'b1, "os5");
      start_a_t(2, 5, 1'b1, 4'b0000);
      idle(55);

      // P=0 means 16 at WIDTH=4
      n0 = cyc + 1;
      push_win(1'b0, 1, n0, 0, 48, 16, 1'b0, "p0");
      start_a_t(1, 0, 1'b0, 4'b0000);
      idle(48);
      push(1'b0, 1, cyc + 1, 1'b0, 1'b0, "p0_stop");
      stop_a_t(4'b0010);

      // stop after 4 clocks, silence, then restart
      n0 = cyc + 1;
      push_win(1'b0, 0, n0, 0, 3, 10, 1'b0, "stop_run");
      for (int k = 4; k <= 34; k++) push(1'b0, 0, n0 + k, 1'b0, 1'b0, "stop_held");
      start_a_t(0, 10, 1'b0, 4'b0000);
      idle(3);
      stop_a_t(4'b0001);
      idle(30);
      n1 = cyc + 1;
      push_win(1'b0, 0, n1, 0, 10, 10, 1'b0, "restart");
      start_a_t(0, 10, 1'b0, 4'b0000);
      idle(10);
      push(1'b0, 0, cyc + 1, 1'b0, 1'b0, "restart_stop");
      stop_a_t(4'b0001);

      // restart exactly on the expiry edge, then start+stop together
      n0 = cyc + 1;
      push_win(1'b0, 1, n0, 0, 7, 4, 1'b0, "p4");
      start_a_t(1, 4, 1'b0, 4'b0000);
      idle(7);
      n1 = cyc + 1;
      push_win(1'b0, 1, n1, 0, 13, 6, 1'b0, "p6_on_expiry");
      start_a_t(1, 6, 1'b0, 4'b0000);
      idle(13);
      n2 = cyc + 1;
      for (int k = 0; k <= 3; k++) push(1'b0, 3, n2 + k, 1'b0, 1'b1, "start_wins");
      start_a_t(3, 7, 1'b0, 4'b1000);
      idle(3);
      // ch1 would tick on this edge; the stop must suppress it
      push(1'b0, 1, cyc + 1, 1'b0, 1'b0, "stop_suppress");
      push(1'b0, 3, cyc + 1, 1'b0, 1'b0, "stop_ch3");
      stop_a_t(4'b1010);

      // simultaneous ticks on two channels
      n0 = cyc + 1;
      push_win(1'b0, 0, n0, 0, 9, 3, 1'b0, "multi_c0");
      start_a_t(0, 3, 1'b0, 4'b0000);
      n1 = cyc + 1;
      push_win(1'b0, 2, n1, 0, 8, 2, 1'b0, "multi_c2");
      start_a_t(2, 2, 1'b0, 4'b0000);
      idle(8);
      push(1'b0, 0, cyc + 1, 1'b0, 1'b0, "multi_stop");
      push(1'b0, 2, cyc + 1, 1'b0, 1'b0, "multi_stop");
      stop_a_t(4'b0101);

      // Instance B: prescaler strobes on edges e with (e - r_b - 1) % 4 == 0
      n0 = cyc + 1;
      s1 = n0 + 1;
      while (((s1 - r_b - 1) % 4) != 0) s1++;
      t1 = s1 + 4;
      for (int c = n0; c <= t1 + 15; c++)
         push(1'b1, 3, c, (c >= t1) && ((c - t1) % 8 == 0), 1'b1, "ps4");
      start_b_t(3, 2, 1'b0);
      idle(t1 + 15 - cyc);
      // reset lands on a would-be tick edge, together with a start on ch0
      m = cyc + 1;
      for (int k = 0; k <= 40; k++) push(1'b1, 3, m + k, 1'b0, 1'b0, "ps4_reset");
      push(1'b1, 0, m, 1'b0, 1'b0, "reset_prio");
      reset_b = 1'b1; start_b = 1'b1; chan_b = 2'd0; per_b = 11'd3;
      @(negedge clk);
      reset_b = 1'b0; start_b = 1'b0;
      idle(40);

      @(negedge clk);
      #1;
      check_eq("sb_drain", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
